spi_slave_duplex: RTL and testbench

Parametrised full-duplex SPI slave; successor to the receive-only 8-bit SPI slave. Runs on the FPGA system clock (25 MHz) and oversamples SCK/CS/MOSI from the RP2040 master. Supports all four SPI modes, configurable word width and multi-word frames under one CS assertion. Returns data to the master on MISO from a one-word transmit buffer loaded by the RISC-V side.

---
 rtl/spi_slave_duplex.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_slave_duplex.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_duplex.sv
// spi_slave_duplex: parametrised full-duplex SPI slave, oversampled on the system clock.
// Handles all four SPI modes, WORD_W-bit words (MSB first) and multi-word frames per CS.
// Optional feature macro: SPI_SLAVE_DUPLEX_OVR_EN enables the sticky rx_overrun flag;
// when undefined rx_overrun is tied to 0.
module spi_slave_duplex #(
    parameter int unsigned WORD_W      = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              rx_overrun,
    output logic              frame_active
);

    localparam int unsigned CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    // Synchroniser chains; CS resets deasserted and SCK to its idle level so that
    // leaving reset never looks like a frame start or a clock edge.
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_prev_q;

    logic sck_s;
    logic cs_s;
    logic mosi_s;
    logic leading_edge;
    logic trailing_edge;
    logic sample_edge;
    logic shift_edge;

    state_e            state_q,    state_d;
    logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [WORD_W-1:0] rx_shift_q, rx_shift_d;
    logic [WORD_W-1:0] tx_shift_q, tx_shift_d;
    logic [WORD_W-1:0] tx_buf_q,   tx_buf_d;
    logic              tx_full_q,  tx_full_d;
    logic [WORD_W-1:0] rx_data_q,  rx_data_d;
    logic              rx_valid_q, rx_valid_d;

    logic load_word;
    logic tx_consume;
    logic word_done;

    // Pin synchronisers plus the extra SCK flop used for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_sync_q  <= {SYNC_STAGES{CPOL}};
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= CPOL;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    // Edge pulses: leading leaves the idle level, trailing returns to it.
    always_comb begin
        sck_s         = sck_sync_q[SYNC_STAGES-1];
        cs_s          = cs_sync_q[SYNC_STAGES-1];
        mosi_s        = mosi_sync_q[SYNC_STAGES-1];
        leading_edge  = (sck_prev_q == CPOL) && (sck_s != CPOL);
        trailing_edge = (sck_prev_q != CPOL) && (sck_s == CPOL);
        sample_edge   = CPHA ? trailing_edge : leading_edge;
        shift_edge    = CPHA ? leading_edge : trailing_edge;
    end

    // FSM next state, shift registers and word-boundary TX loads.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        load_word  = 1'b0;
        word_done  = 1'b0;
        case (state_q)
            StIdle: begin
                bit_cnt_d  = '0;
                tx_shift_d = '0;
                if (!cs_s) begin
                    state_d = StShift;
                    // CPHA=0 masters sample the MSB on the first edge, so it must be ready now.
                    if (!CPHA) begin
                        load_word = 1'b1;
                    end
                end
            end
            StShift: begin
                if (cs_s) begin
                    // Frame ended: drop any partial word.
                    state_d    = StIdle;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    tx_shift_d = '0;
                end else if (sample_edge) begin
                    rx_shift_d = {rx_shift_q[WORD_W-2:0], mosi_s};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        word_done = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (shift_edge) begin
                    // A shift edge at bit 0 opens a new word: CPHA=0 after the last sample,
                    // CPHA=1 on the first leading edge of the word.
                    if (bit_cnt_q == '0) begin
                        load_word = 1'b1;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        tx_consume = load_word && tx_full_q;
        if (load_word) begin
            tx_shift_d = tx_full_q ? tx_buf_q : '0;
        end
    end

    // One-word TX buffer; a load colliding with consumption is dropped since tx_ready=0.
    always_comb begin
        tx_full_d = tx_full_q;
        tx_buf_d  = tx_buf_q;
        if (tx_consume) begin
            tx_full_d = 1'b0;
        end else if (tx_load && !tx_full_q) begin
            tx_full_d = 1'b1;
            tx_buf_d  = tx_data;
        end
    end

    // Received word hand-off; a completion beats a simultaneous rx_ack.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        if (word_done) begin
            rx_data_d  = {rx_shift_q[WORD_W-2:0], mosi_s};
            rx_valid_d = 1'b1;
        end else if (rx_ack) begin
            rx_valid_d = 1'b0;
        end
    end

    // Core state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            tx_buf_q   <= '0;
            tx_full_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            tx_buf_q   <= tx_buf_d;
            tx_full_q  <= tx_full_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

`ifdef SPI_SLAVE_DUPLEX_OVR_EN
    logic rx_ovr_q, rx_ovr_d;

    // Sticky overrun: set when a word lands on unread data, cleared by an ack
    // that does not coincide with a completion.
    always_comb begin
        rx_ovr_d = rx_ovr_q;
        if (word_done && rx_valid_q) begin
            rx_ovr_d = 1'b1;
        end else if (rx_ack && !word_done) begin
            rx_ovr_d = 1'b0;
        end
    end

    // Overrun flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ovr_q <= 1'b0;
        end else begin
            rx_ovr_q <= rx_ovr_d;
        end
    end

    assign rx_overrun = rx_ovr_q;
`else
    assign rx_overrun = 1'b0;
`endif

    assign miso         = (state_q == StShift) ? tx_shift_q[WORD_W-1] : 1'b0;
    assign tx_ready     = ~tx_full_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign frame_active = ~cs_s;

endmodule

// File: tb/tb_spi_slave_duplex.sv
// tb_spi_slave_duplex: self-checking bench for spi_slave_duplex.
// Three instances: mode 0 / 8 bit, mode 3 / 8 bit, mode 1 / 16 bit. A behavioural SPI master
// drives them; a simple TX-buffer model predicts what MISO returns.
`timescale 1ns/1ps
module tb_spi_slave_duplex;

    localparam int H   = 10;  // clk cycles per SCK half period
    localparam int CAP = 6;   // clk cycles after the last sample edge before reading rx_data
`ifdef SPI_SLAVE_DUPLEX_OVR_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #20 clk = ~clk;

    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic [2:0]  cs_v = 3'b111;
    logic [2:0]  tx_load_v = 3'b000;
    logic [2:0]  rx_ack_v = 3'b000;
    logic [15:0] tx_data = 16'h0;

    logic       miso0, txr0, rxv0, ovr0, fa0;
    logic       miso1, txr1, rxv1, ovr1, fa1;
    logic       miso2, txr2, rxv2, ovr2, fa2;
    logic [7:0] rxd0, rxd1;
    logic [15:0] rxd2;

    spi_slave_duplex #(.WORD_W(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_dut0 (
        .clk(clk), .rst(rst), .sck(sck), .cs(cs_v[0]), .mosi(mosi), .miso(miso0),
        .tx_data(tx_data[7:0]), .tx_load(tx_load_v[0]), .tx_ready(txr0), .rx_data(rxd0),
        .rx_valid(rxv0), .rx_ack(rx_ack_v[0]), .rx_overrun(ovr0), .frame_active(fa0)
    );
    spi_slave_duplex #(.WORD_W(8), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u_dut1 (
        .clk(clk), .rst(rst), .sck(sck), .cs(cs_v[1]), .mosi(mosi), .miso(miso1),
        .tx_data(tx_data[7:0]), .tx_load(tx_load_v[1]), .tx_ready(txr1), .rx_data(rxd1),
        .rx_valid(rxv1), .rx_ack(rx_ack_v[1]), .rx_overrun(ovr1), .frame_active(fa1)
    );
    spi_slave_duplex #(.WORD_W(16), .CPOL(1'b0), .CPHA(1'b1), .SYNC_STAGES(2)) u_dut2 (
        .clk(clk), .rst(rst), .sck(sck), .cs(cs_v[2]), .mosi(mosi), .miso(miso2),
        .tx_data(tx_data), .tx_load(tx_load_v[2]), .tx_ready(txr2), .rx_data(rxd2),
        .rx_valid(rxv2), .rx_ack(rx_ack_v[2]), .rx_overrun(ovr2), .frame_active(fa2)
    );

    int          sel = 0;
    logic        miso_s, txr_s, rxv_s, ovr_s, fa_s;
    logic [15:0] rxd_s;
    always_comb begin
        case (sel)
            1: begin miso_s = miso1; txr_s = txr1; rxv_s = rxv1; ovr_s = ovr1; fa_s = fa1;
                     rxd_s = {8'h00, rxd1}; end
            2: begin miso_s = miso2; txr_s = txr2; rxv_s = rxv2; ovr_s = ovr2; fa_s = fa2;
                     rxd_s = rxd2; end
            default: begin miso_s = miso0; txr_s = txr0; rxv_s = rxv0; ovr_s = ovr0;
                     fa_s = fa0; rxd_s = {8'h00, rxd0}; end
        endcase
    end

    int errors = 0;
    int checks = 0;

    // Reference model of each TX buffer.
    bit          m_full[3];
    logic [15:0] m_buf[3];

    // Per-frame stimulus and captured results.
    logic [15:0] mo[4];
    logic [15:0] mi[4];
    logic [15:0] cap_rx[4];
    logic        cap_v[4];
    logic        cap_ack_v[4];
    logic        cap_ovr[4];

    function automatic logic [15:0] wmask(input int d);
        return (d == 2) ? 16'hFFFF : 16'h00FF;
    endfunction

    // A frame start takes the buffered word if there is one, else zeros; later words are zeros.
    function automatic logic [15:0] model_frame(input int d);
        logic [15:0] v;
        v = m_full[d] ? m_buf[d] : 16'h0;
        m_full[d] = 1'b0;
        return v;
    endfunction

    task automatic tx_push(input int d, input logic [15:0] v);
        tx_data = v;
        tx_load_v[d] = 1'b1;
        @(posedge clk); #1;
        tx_load_v[d] = 1'b0;
        if (!m_full[d]) begin
            m_full[d] = 1'b1;
            m_buf[d] = v & wmask(d);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Behavioural SPI master: sends mo[0..nwords-1], records MISO words and rx state per word.
    task automatic spi_xfer(input int d, input int nwords, input bit ack, input int abort_bits,
                            input bit mid_load, input logic [15:0] mid_val);
        bit cpol, cpha, aborted;
        int width, nb;
        logic [15:0] rv;
        cpol = (d == 1);
        cpha = (d != 0);
        width = (d == 2) ? 16 : 8;
        nb = 0;
        aborted = 1'b0;
        sel = d;
        sck = cpol;
        mosi = 1'b0;
        wait_cyc(4);
        cs_v[d] = 1'b0;
        if (mid_load) begin
            wait_cyc(4);
            tx_push(d, mid_val);
            wait_cyc(H - 5);
        end else begin
            wait_cyc(H);
        end
        for (int w = 0; w < nwords; w++) begin
            rv = 16'h0;
            for (int b = width - 1; b >= 0; b--) begin
                if (abort_bits > 0 && nb == abort_bits) begin
                    aborted = 1'b1;
                    break;
                end
                if (!cpha) begin
                    mosi = mo[w][b];
                    wait_cyc(H);
                    rv = {rv[14:0], miso_s};
                    sck = ~cpol;
                end else begin
                    sck = ~cpol;
                    mosi = mo[w][b];
                    wait_cyc(H);
                    rv = {rv[14:0], miso_s};
                    sck = cpol;
                end
                if (b == 0) begin
                    wait_cyc(CAP);
                    cap_rx[w] = rxd_s;
                    cap_v[w] = rxv_s;
                    cap_ovr[w] = ovr_s;
                    if (ack) begin
                        rx_ack_v[d] = 1'b1;
                        wait_cyc(1);
                        rx_ack_v[d] = 1'b0;
                        cap_ack_v[w] = rxv_s;
                        wait_cyc(H - CAP - 1);
                    end else begin
                        wait_cyc(H - CAP);
                    end
                end else begin
                    wait_cyc(H);
                end
                if (!cpha) sck = cpol;
                nb++;
            end
            mi[w] = rv & wmask(d);
            if (aborted) break;
        end
        wait_cyc(H);
        cs_v[d] = 1'b1;
        wait_cyc(2 * H);
    endtask

    task automatic test_reset();
        sel = 0;
        checks++; if (miso0 !== 1'b0) begin errors++; $display("FAIL rst_miso: got %b expected 0", miso0); end
        checks++; if (txr0 !== 1'b1) begin errors++; $display("FAIL rst_tx_ready: got %b expected 1", txr0); end
        checks++; if (rxd0 !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %h expected 00", rxd0); end
        checks++; if (rxv0 !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b expected 0", rxv0); end
        checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0", ovr0); end
        checks++; if (fa0 !== 1'b0) begin errors++; $display("FAIL rst_frame_active: got %b expected 0", fa0); end
        checks++; if (rxd2 !== 16'h0) begin errors++; $display("FAIL rst_rx_data16: got %h expected 0000", rxd2); end
    endtask

    task automatic test_mode0();
        logic [15:0] exp;
        tx_push(0, 16'h003C);
        checks++; if (txr0 !== 1'b0) begin errors++; $display("FAIL m0_tx_full: got %b expected 0", txr0); end
        tx_push(0, 16'h0055);  // buffer full: must be ignored
        exp = model_frame(0);
        mo[0] = 16'h00A5;
        spi_xfer(0, 1, 1'b1, 0, 1'b0, 16'h0);
        checks++; if (cap_rx[0] !== 16'h00A5) begin errors++; $display("FAIL m0_rx: got %h expected 00a5", cap_rx[0]); end
        checks++; if (cap_v[0] !== 1'b1) begin errors++; $display("FAIL m0_valid: got %b expected 1", cap_v[0]); end
        checks++; if (cap_ack_v[0] !== 1'b0) begin errors++; $display("FAIL m0_ack_clear: got %b expected 0", cap_ack_v[0]); end
        checks++; if (mi[0] !== exp) begin errors++; $display("FAIL m0_miso: got %h expected %h", mi[0], exp); end
        checks++; if (txr0 !== 1'b1) begin errors++; $display("FAIL m0_tx_ready: got %b expected 1", txr0); end
    endtask

    task automatic test_mode3_two_words();
        logic [15:0] exp;
        tx_push(1, 16'h00F0);
        exp = model_frame(1);
        mo[0] = 16'h0012;
        mo[1] = 16'h0034;
        spi_xfer(1, 2, 1'b1, 0, 1'b0, 16'h0);
        checks++; if (cap_rx[0] !== 16'h0012) begin errors++; $display("FAIL m3_rx0: got %h expected 0012", cap_rx[0]); end
        checks++; if (cap_rx[1] !== 16'h0034) begin errors++; $display("FAIL m3_rx1: got %h expected 0034", cap_rx[1]); end
        checks++; if (cap_v[1] !== 1'b1) begin errors++; $display("FAIL m3_valid1: got %b expected 1", cap_v[1]); end
        checks++; if (mi[0] !== exp) begin errors++; $display("FAIL m3_miso0: got %h expected %h", mi[0], exp); end
        checks++; if (mi[1] !== 16'h0) begin errors++; $display("FAIL m3_miso1: got %h expected 0000", mi[1]); end
    endtask

    task automatic test_mode1_w16();
        logic [15:0] exp;
        tx_push(2, 16'($urandom));
        exp = model_frame(2);
        mo[0] = 16'hBEEF;
        mo[1] = 16'($urandom);
        spi_xfer(2, 2, 1'b1, 0, 1'b0, 16'h0);
        checks++; if (cap_rx[0] !== 16'hBEEF) begin errors++; $display("FAIL w16_rx0: got %h expected beef", cap_rx[0]); end
        checks++; if (cap_rx[1] !== mo[1]) begin errors++; $display("FAIL w16_rx1: got %h expected %h", cap_rx[1], mo[1]); end
        checks++; if (mi[0] !== exp) begin errors++; $display("FAIL w16_miso0: got %h expected %h", mi[0], exp); end
    endtask

    task automatic test_cs_abort();
        logic [15:0] exp, tval;
        tval = 16'($urandom_range(1, 255));
        exp = model_frame(0);
        mo[0] = 16'($urandom) & 16'h00FF;
        spi_xfer(0, 1, 1'b1, 5, 1'b1, tval);
        checks++; if (rxv0 !== 1'b0) begin errors++; $display("FAIL abort_no_valid: got %b expected 0", rxv0); end
        checks++; if (txr0 !== 1'b0) begin errors++; $display("FAIL abort_tx_kept: got %b expected 0", txr0); end
        exp = model_frame(0);
        mo[0] = 16'h0081;
        spi_xfer(0, 1, 1'b1, 0, 1'b0, 16'h0);
        checks++; if (cap_rx[0] !== 16'h0081) begin errors++; $display("FAIL abort_next_rx: got %h expected 0081", cap_rx[0]); end
        checks++; if (mi[0] !== exp) begin errors++; $display("FAIL abort_tx_sent: got %h expected %h", mi[0], exp); end
    endtask

    task automatic test_overrun();
        logic [15:0] exp;
        exp = model_frame(0);
        mo[0] = 16'($urandom) & 16'h00FF;
        mo[1] = 16'($urandom) & 16'h00FF;
        spi_xfer(0, 2, 1'b0, 0, 1'b0, 16'h0);
        checks++; if (cap_ovr[0] !== 1'b0) begin errors++; $display("FAIL ovr_first: got %b expected 0", cap_ovr[0]); end
        checks++; if (cap_rx[1] !== mo[1]) begin errors++; $display("FAIL ovr_rx: got %h expected %h", cap_rx[1], mo[1]); end
        checks++; if (cap_ovr[1] !== EXP_OVR) begin errors++; $display("FAIL ovr_flag: got %b expected %b", cap_ovr[1], EXP_OVR); end
        checks++; if (mi[0] !== exp) begin errors++; $display("FAIL ovr_miso: got %h expected %h", mi[0], exp); end
        rx_ack_v[0] = 1'b1;
        wait_cyc(1);
        rx_ack_v[0] = 1'b0;
        checks++; if (rxv0 !== 1'b0) begin errors++; $display("FAIL ovr_ack_valid: got %b expected 0", rxv0); end
        checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL ovr_ack_flag: got %b expected 0", ovr0); end
    endtask

    task automatic test_random();
        logic [15:0] exp;
        int d, n;
        for (int i = 0; i < 6; i++) begin
            d = $urandom_range(0, 2);
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) tx_push(d, 16'($urandom));
            exp = model_frame(d);
            for (int w = 0; w < n; w++) mo[w] = 16'($urandom) & wmask(d);
            spi_xfer(d, n, 1'b1, 0, 1'b0, 16'h0);
            for (int w = 0; w < n; w++) begin
                checks++; if (cap_rx[w] !== mo[w]) begin errors++;
                    $display("FAIL rnd_rx d%0d w%0d: got %h expected %h", d, w, cap_rx[w], mo[w]); end
                checks++; if (mi[w] !== ((w == 0) ? exp : 16'h0)) begin errors++;
                    $display("FAIL rnd_miso d%0d w%0d: got %h expected %h", d, w, mi[w],
                             (w == 0) ? exp : 16'h0); end
            end
        end
    endtask

    task automatic test_reset_mid_word();
        logic [15:0] exp;
        exp = model_frame(0);
        mo[0] = 16'($urandom) & 16'h00FF;
        spi_xfer(0, 1, 1'b0, 0, 1'b0, 16'h0);  // leaves rx_valid set
        tx_push(0, 16'h0099);
        sel = 0;
        sck = 1'b0;
        cs_v[0] = 1'b0;
        wait_cyc(H);
        for (int b = 0; b < 3; b++) begin
            mosi = b[0];
            wait_cyc(H);
            sck = 1'b1;
            wait_cyc(H);
            sck = 1'b0;
        end
        mosi = 1'b1;
        wait_cyc(H);
        sck = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        #1;
        checks++; if (miso0 !== 1'b0) begin errors++; $display("FAIL rmid_miso: got %b expected 0", miso0); end
        checks++; if (txr0 !== 1'b1) begin errors++; $display("FAIL rmid_tx_ready: got %b expected 1", txr0); end
        checks++; if (rxd0 !== 8'h00) begin errors++; $display("FAIL rmid_rx_data: got %h expected 00", rxd0); end
        checks++; if (rxv0 !== 1'b0) begin errors++; $display("FAIL rmid_rx_valid: got %b expected 0", rxv0); end
        checks++; if (fa0 !== 1'b0) begin errors++; $display("FAIL rmid_frame_active: got %b expected 0", fa0); end
        for (int i = 0; i < 3; i++) m_full[i] = 1'b0;
        cs_v = 3'b111;
        sck = 1'b0;
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(4);
        exp = model_frame(0);
        mo[0] = 16'h005A;
        spi_xfer(0, 1, 1'b1, 0, 1'b0, 16'h0);
        checks++; if (cap_rx[0] !== 16'h005A) begin errors++; $display("FAIL rmid_after_rx: got %h expected 005a", cap_rx[0]); end
        checks++; if (mi[0] !== exp) begin errors++; $display("FAIL rmid_after_miso: got %h expected %h", mi[0], exp); end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_full[i] = 1'b0;
            m_buf[i] = 16'h0;
        end
        wait_cyc(3);
        test_reset();
        rst = 1'b1;
        wait_cyc(3);
        test_mode0();
        test_mode3_two_words();
        test_mode1_w16();
        test_cs_abort();
        test_overrun();
        test_random();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #20ms;
        $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
